// File: rtl/ca_row_sequencer.sv
// ca_row_sequencer: drives an external 3-input elementary-CA rule block one
// cell per cycle. It presents each cell's neighbourhood, collects the rule
// result into a shadow row, and commits that row as the next generation.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting; accepts row loads and start requests
// SCAN   | presenting the neighbourhood of cell idx; capturing rule_out
// COMMIT | copying the shadow row into the visible row; counting the step
module ca_row_sequencer #(
  parameter int WIDTH    = 16,
  parameter int STEPS_W  = 8,
  parameter int BOUNDARY = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  input  logic [WIDTH-1:0]   load_data,
  output logic               load_ready,
  input  logic               start,
  input  logic [STEPS_W-1:0] num_steps,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   state_out,
  output logic [STEPS_W-1:0] steps_done,
  output logic               nb_valid,
  output logic               nb_left,
  output logic               nb_center,
  output logic               nb_right,
  input  logic               rule_out
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_row;
  logic [WIDTH-1:0]   r_next;
  logic [IDX_W-1:0]   r_idx;
  logic [STEPS_W-1:0] r_steps_done;
  logic [STEPS_W-1:0] r_num_steps;
  logic [STEPS_W-1:0] r_run_cnt;
  logic               r_done_zero;

  logic               w_load_acc;
  logic               w_start_acc;
  logic               w_start_zero;
  logic               w_last_idx;
  logic               w_last_gen;
  logic               w_left_cell;
  logic               w_center_cell;
  logic               w_right_cell;

  // Handshake qualifiers; a load in the same cycle as start takes priority.
  always_comb begin
    w_load_acc   = (r_state == S_IDLE) && load_valid;
    w_start_acc  = (r_state == S_IDLE) && !load_valid && start && (num_steps != '0);
    w_start_zero = (r_state == S_IDLE) && !load_valid && start && (num_steps == '0);
    w_last_idx   = (r_idx == LAST_IDX);
    // The run length is measured from the accepted start, so every run
    // takes exactly num_steps generations regardless of earlier runs.
    w_last_gen   = (STEPS_W'(r_run_cnt + 1'b1) == r_num_steps);
  end

  // Neighbourhood of the cell under scan, with wrap-around or null edges.
  always_comb begin
    w_center_cell = r_row[r_idx];
    if (w_last_idx) begin
      w_left_cell = (BOUNDARY != 0) ? 1'b0 : r_row[0];
    end else begin
      w_left_cell = r_row[r_idx + IDX_W'(1)];
    end
    if (r_idx == '0) begin
      w_right_cell = (BOUNDARY != 0) ? 1'b0 : r_row[WIDTH-1];
    end else begin
      w_right_cell = r_row[r_idx - IDX_W'(1)];
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    load_ready  = 1'b0;
    nb_valid    = 1'b0;
    nb_left     = 1'b0;
    nb_center   = 1'b0;
    nb_right    = 1'b0;
    done        = r_done_zero;
    unique case (r_state)
      S_IDLE: begin
        load_ready = 1'b1;
        if (w_start_acc) begin
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        busy      = 1'b1;
        nb_valid  = 1'b1;
        nb_left   = w_left_cell;
        nb_center = w_center_cell;
        nb_right  = w_right_cell;
        if (w_last_idx) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        busy = 1'b1;
        if (w_last_gen) begin
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Visible row and shadow row; the visible row only moves on load or commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row  <= '0;
      r_next <= '0;
    end else begin
      if (w_load_acc) begin
        r_row <= load_data;
      end else if (r_state == S_COMMIT) begin
        r_row <= r_next;
      end
      if (r_state == S_SCAN) begin
        r_next[r_idx] <= rule_out;
      end
    end
  end

  // Scan index: restarts at cell 0 for every generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (r_state == S_SCAN) begin
      r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_idx <= '0;
    end
  end

  // Generation counters: steps since load (free-wrapping) and steps in this run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_steps_done <= '0;
      r_run_cnt    <= '0;
      r_num_steps  <= '0;
    end else begin
      if (w_load_acc) begin
        r_steps_done <= '0;
      end else if (r_state == S_COMMIT) begin
        r_steps_done <= r_steps_done + 1'b1;
      end
      if (w_start_acc) begin
        r_num_steps <= num_steps;
        r_run_cnt   <= '0;
      end else if (r_state == S_COMMIT) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end
  end

  // A zero-length run completes with a done pulse on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_zero <= 1'b0;
    end else begin
      r_done_zero <= w_start_zero;
    end
  end

  assign state_out  = r_row;
  assign steps_done = r_steps_done;

endmodule
